// File: rtl/shift_mult_ctrl_if.sv
// Request/result bus between the requesters, the shift-multiplier datapath and its controller.
// master = controller side, slave = requesters plus multiplier/serializer side.
interface shift_mult_ctrl_if #(
   parameter int WIDTH = 23
);
   logic             req0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             req1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic             mul_start;
   logic             mul_done;
   logic             sz;
   logic             z_in;
   logic             fz;
   logic             ser_clr;
   logic [WIDTH-1:0] result;
   logic             ack0;
   logic             ack1;
   logic             err;
   logic             busy;
   logic             owner;

   modport master (
      input  req0, a0, b0, req1, a1, b1, mul_done, z_in, fz,
      output mul_a, mul_b, mul_start, sz, ser_clr, result, ack0, ack1, err, busy, owner
   );

   modport slave (
      output req0, a0, b0, req1, a1, b1, mul_done, z_in, fz,
      input  mul_a, mul_b, mul_start, sz, ser_clr, result, ack0, ack1, err, busy, owner
   );
endinterface

// File: rtl/shift_mult_ctrl.sv
// Round-robin sequencer for a shared multiplier and serial shift-out stage; grant to ack is
// 1 + mul cycles + (WIDTH+3) + 2. Requesters hold req as a level until their one-cycle ack.
module shift_mult_ctrl #(
   parameter int WIDTH  = 23,
   parameter int MUL_TO = 64,
   parameter int SER_TO = 32
) (
   input  logic              clk,
   input  logic              rst,
   shift_mult_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_MUL, S_SHIFT, S_CLEAR, S_ACK
   } state_t;

   localparam logic [7:0] MUL_LIM   = 8'(MUL_TO - 1);
   localparam logic [7:0] CAP_FIRST = 8'd2;
   localparam logic [7:0] CAP_LAST  = 8'(WIDTH + 1);
   localparam logic [7:0] SER_LIM   = 8'(SER_TO);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic             owner_q, owner_d, last_q, last_d, err_q, err_d;
   logic [7:0]       cnt_q, cnt_d, cnt_inc;
   logic             grant_vld, grant_idx;

   assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
   assign grant_vld = bus.req0 | bus.req1;
   // On a tie the requester that was not served last wins.
   assign grant_idx = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      owner_d = owner_q;
      last_d  = last_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               owner_d = grant_idx;
               a_d     = grant_idx ? bus.a1 : bus.a0;
               b_d     = grant_idx ? bus.b1 : bus.b0;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_MUL;
         end
         S_MUL: begin
            if (bus.mul_done) begin
               cnt_d   = '0;
               state_d = S_SHIFT;
            end else if (cnt_q >= MUL_LIM) begin
               err_d   = 1'b1;
               state_d = S_CLEAR;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_SHIFT: begin
            // cnt_q counts edges since the first one with sz high; bits land two edges later.
            cnt_d = cnt_inc;
            if (cnt_q >= CAP_FIRST && cnt_q <= CAP_LAST) begin
               res_d = {bus.z_in, res_q[WIDTH-1:1]};
            end
            if (bus.fz) begin
               err_d   = err_q | (cnt_q <= CAP_LAST);
               state_d = S_CLEAR;
            end else if (cnt_q >= SER_LIM) begin
               err_d   = 1'b1;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_ACK;
         end
         S_ACK: begin
            last_d  = owner_q;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.mul_a     = a_q;
   assign bus.mul_b     = b_q;
   assign bus.mul_start = (state_q == S_LAUNCH);
   assign bus.sz        = (state_q == S_SHIFT);
   assign bus.ser_clr   = (state_q == S_CLEAR);
   assign bus.result    = res_q;
   assign bus.ack0      = (state_q == S_ACK) & ~owner_q;
   assign bus.ack1      = (state_q == S_ACK) &  owner_q;
   assign bus.err       = (state_q == S_ACK) &  err_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.owner     = owner_q;
endmodule

// File: tb/tb_shift_mult_ctrl.sv
// Directed bench for shift_mult_ctrl with a cycle-stepped multiplier and serializer model.
module tb_shift_mult_ctrl;
   localparam int W = 23;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   shift_mult_ctrl_if #(.WIDTH(W)) ifc();

   shift_mult_ctrl #(.WIDTH(W), .MUL_TO(64), .SER_TO(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int n_vec = 0;
   int n_bad = 0;

   int busy_cyc, idle_cyc, sz_cyc, clr_cnt, start_cnt, ack_cnt;
   logic             ack_seen, ack_own, ack_err;
   logic [W-1:0]     ack_res, ack_ma, ack_mb;

   int           mul_lat;
   int           mcnt;
   int           k;
   int           fz_at;
   logic [W-1:0] ser_dat;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_stats();
      busy_cyc  = 0;
      idle_cyc  = 0;
      sz_cyc    = 0;
      clr_cnt   = 0;
      start_cnt = 0;
      ack_cnt   = 0;
   endtask

   // One clock: observe outputs at the falling edge, then drive the next inputs.
   task automatic tick();
      @(negedge clk);
      if (ifc.busy) busy_cyc++; else idle_cyc++;
      if (ifc.sz) sz_cyc++;
      if (ifc.ser_clr) clr_cnt++;
      if (ifc.mul_start) start_cnt++;
      if (ifc.ack0 || ifc.ack1) begin
         ack_cnt++;
         ack_seen = 1'b1;
         ack_own  = ifc.owner;
         ack_res  = ifc.result;
         ack_err  = ifc.err;
         ack_ma   = ifc.mul_a;
         ack_mb   = ifc.mul_b;
         if (ifc.ack0) ifc.req0 = 1'b0;
         if (ifc.ack1) ifc.req1 = 1'b0;
      end
      ifc.mul_done = 1'b0;
      if (!rst) begin
         mcnt = 0;
      end else if (ifc.mul_start && mul_lat != 0) begin
         mcnt = 1;
      end else if (mcnt != 0) begin
         mcnt++;
         if (mcnt == mul_lat + 1) begin
            ifc.mul_done = 1'b1;
            mcnt = 0;
         end
      end
      if (!rst || ifc.ser_clr) begin
         k        = 0;
         ifc.fz   = 1'b0;
         ifc.z_in = 1'b0;
      end else if (ifc.sz) begin
         ifc.z_in = (k >= 2 && k <= W + 1) ? ser_dat[k-2] : 1'b0;
         if (k >= fz_at) ifc.fz = 1'b1;
         k++;
      end
   endtask

   task automatic wait_ack(input int bound);
      int n = 0;
      ack_seen = 1'b0;
      while (!ack_seen && n < bound) begin
         tick();
         n++;
      end
      if (!ack_seen) chk("ack_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      ifc.req0 = 1'b0;
      ifc.req1 = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      ifc.req0 = 1'b0; ifc.req1 = 1'b0;
      ifc.a0 = '0; ifc.b0 = '0; ifc.a1 = '0; ifc.b1 = '0;
      ifc.mul_done = 1'b0; ifc.z_in = 1'b0; ifc.fz = 1'b0;
      mul_lat = 4; mcnt = 0; k = 0; fz_at = W + 2; ser_dat = '0;
      ack_seen = 1'b0; ack_own = 1'b0; ack_err = 1'b0;
      ack_res = '0; ack_ma = '0; ack_mb = '0;
      clr_stats();

      // Reset state
      repeat (2) tick();
      chk("rst_ctl", {ifc.mul_start, ifc.sz, ifc.ser_clr, ifc.ack0, ifc.ack1,
                      ifc.err, ifc.busy, ifc.owner}, 64'd0);
      chk("rst_result", ifc.result, 64'd0);
      rst = 1'b1;
      tick();

      // Single request; operands change after grant and must be ignored
      clr_stats();
      ifc.a0 = 23'h000003; ifc.b0 = 23'h000005;
      mul_lat = 4; fz_at = W + 2; ser_dat = 23'h00000F;
      ifc.req0 = 1'b1;
      repeat (3) tick();
      ifc.a0 = 23'h000007; ifc.b0 = 23'h000009;
      wait_ack(200);
      chk("t1_owner", ack_own, 64'd0);
      chk("t1_result", ack_res, 64'h00000F);
      chk("t1_err", ack_err, 64'd0);
      chk("t1_mul_a", ack_ma, 64'h3);
      chk("t1_mul_b", ack_mb, 64'h5);
      chk("t1_sz_cycles", sz_cyc, 64'd26);
      chk("t1_clr", clr_cnt, 64'd1);
      chk("t1_start", start_cnt, 64'd1);
      chk("t1_busy_cycles", busy_cyc, 64'd33);
      tick();
      chk("t1_single_ack", ack_cnt, 64'd1);
      chk("t1_idle", ifc.busy, 64'd0);

      // Round-robin: simultaneous requests after reset, re-armed twice
      do_reset();
      ifc.a0 = 23'h11; ifc.b0 = 23'h12; ifc.a1 = 23'h22; ifc.b1 = 23'h23;
      mul_lat = 3; fz_at = W + 2; ser_dat = 23'h001234;
      ifc.req0 = 1'b1; ifc.req1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ack(200);
         chk("rr_owner", ack_own, 64'(i % 2));
         chk("rr_mul_a", ack_ma, (i % 2 != 0) ? 64'h22 : 64'h11);
         chk("rr_result", ack_res, 64'h001234);
         if (i > 0) chk("rr_gap", idle_cyc, 64'd1);
         idle_cyc = 0;
         tick();
         if (i < 2) begin
            if (ack_own) ifc.req1 = 1'b1; else ifc.req0 = 1'b1;
         end
      end

      // Multiplier never finishes
      clr_stats();
      mul_lat = 0;
      ifc.req0 = 1'b1;
      wait_ack(300);
      chk("mto_err", ack_err, 64'd1);
      chk("mto_sz", sz_cyc, 64'd0);
      chk("mto_clr", clr_cnt, 64'd1);
      chk("mto_busy_cycles", busy_cyc, 64'd67);

      // Serializer finishes after only 10 bits
      clr_stats();
      mul_lat = 2; fz_at = 12; ser_dat = 23'h0003FF;
      ifc.req1 = 1'b1;
      wait_ack(200);
      chk("early_err", ack_err, 64'd1);
      chk("early_sz_cycles", sz_cyc, 64'd13);
      chk("early_sz_low", ifc.sz, 64'd0);
      chk("early_clr", clr_cnt, 64'd1);

      // Serializer never finishes
      clr_stats();
      mul_lat = 2; fz_at = 1000;
      ifc.req0 = 1'b1;
      wait_ack(200);
      chk("sto_err", ack_err, 64'd1);
      chk("sto_sz_cycles", sz_cyc, 64'd33);

      // Reset in the middle of the shift-out
      clr_stats();
      mul_lat = 2; fz_at = W + 2; ser_dat = 23'h0055AA;
      ifc.req0 = 1'b1;
      begin
         int n = 0;
         while (sz_cyc < 14 && n < 100) begin
            tick();
            n++;
         end
         if (sz_cyc < 14) chk("mid_reach_shift", 64'd0, 64'd1);
      end
      #3 rst = 1'b0;
      ifc.req0 = 1'b0;
      #1;
      chk("mid_rst_ctl", {ifc.mul_start, ifc.sz, ifc.ser_clr, ifc.ack0, ifc.ack1,
                          ifc.err, ifc.busy, ifc.owner}, 64'd0);
      chk("mid_rst_result", ifc.result, 64'd0);
      chk("mid_rst_mul_a", ifc.mul_a, 64'd0);
      repeat (3) tick();
      chk("mid_no_ack", ack_cnt, 64'd0);
      rst = 1'b1;
      tick();
      mul_lat = 4; fz_at = W + 2; ser_dat = 23'h7FFFFF;
      ifc.a1 = 23'h000101;
      ifc.req1 = 1'b1;
      wait_ack(200);
      chk("post_owner", ack_own, 64'd1);
      chk("post_result", ack_res, 64'h7FFFFF);
      chk("post_err", ack_err, 64'd0);
      chk("post_mul_a", ack_ma, 64'h000101);

      // Alternating bit stream checks capture order at both ends
      clr_stats();
      mul_lat = 1; ser_dat = 23'h555555;
      tick();
      ifc.req0 = 1'b1;
      wait_ack(200);
      chk("alt_result", ack_res, 64'h555555);
      chk("alt_err", ack_err, 64'd0);
      chk("alt_sz_cycles", sz_cyc, 64'd26);
      tick();
      chk("alt_result_held", ifc.result, 64'h555555);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/shift_mult_ctrl.md
Name: shift_mult_ctrl

Overview:
- Sequences the shared shift-multiplier datapath for two requesters.
- Grants one requester at a time and latches its operands. Launches the multiply and waits for its done flag.
- Then starts the serial shift-out stage via `sz`, deserializes the returned bit stream into a parallel result, and acks the requester.
- Sits between the request sources and the multiplier/serializer pair; owns the serializer's start and clear.

Parameters:
- WIDTH, 23, operand and result width; equals the serializer bit count.
- MUL_TO, 64, max cycles to wait for `mul_done` after `mul_start`.
- SER_TO, 32, max cycles to wait for `fz` after `sz` first asserts; must be at least WIDTH+3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 request; level, held until ack0.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  WIDTH  requester 0 operand B.
- req1  in  1  requester 1 request; level, held until ack1.
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- mul_a  out  WIDTH  latched operand A to multiplier.
- mul_b  out  WIDTH  latched operand B to multiplier.
- mul_start  out  1  one-cycle multiply launch pulse.
- mul_done  in  1  multiplier finished; level or pulse.
- sz  out  1  serializer start; held high until fz sampled.
- z_in  in  1  serial result bit from serializer, LSB first.
- fz  in  1  serializer finished; sticky until cleared.
- ser_clr  out  1  one-cycle active-high clear to the serializer.
- result  out  WIDTH  deserialized product; valid while ack pulses, held afterwards.
- ack0  out  1  one-cycle completion to requester 0.
- ack1  out  1  one-cycle completion to requester 1.
- err  out  1  coincides with ack; set when the transaction timed out.
- busy  out  1  high in every state except IDLE.
- owner  out  1  index of the current or last grant.

Behaviour:
Reset (rst low, async):
- state=IDLE; all outputs 0; last-owner pointer=1, so req0 wins the first tie.
- Mid-transaction reset aborts silently: no ack is issued and mul_start/sz drop immediately.

States:
- IDLE
  - Arbitrate among asserted reqs, round-robin: the requester other than the last owner wins ties.
  - A single asserted req always wins.
  - On grant: latch a/b into mul_a/mul_b, set owner, go LAUNCH.
  - Grant decision to LAUNCH takes 1 cycle.
- LAUNCH
  - mul_start=1 for exactly this cycle.
  - Reset the timeout counter; go MUL.
- MUL
  - Wait for mul_done=1, then go SHIFT.
  - mul_done high in LAUNCH's cycle is ignored; it must be sampled in MUL.
  - If the timeout counter reaches MUL_TO: set err_flag, go CLEAR; sz is never asserted.
- SHIFT
  - Assert sz and hold it.
  - Let E0 be the first edge with sz=1. Capture z_in on edges E0+2 .. E0+WIDTH+1 (WIDTH samples).
  - Each capture shifts the result register right and inserts z_in at the MSB, so bit0 ends in result[0].
  - After WIDTH samples, wait for fz=1, then drop sz and go CLEAR.
  - If fz is not seen within SER_TO cycles of E0: set err_flag, drop sz, go CLEAR.
  - fz=1 seen before all WIDTH samples: set err_flag, go CLEAR.
- CLEAR
  - ser_clr=1 for one cycle; go ACK.
- ACK
  - Pulse ack[owner]=1; err=err_flag for that cycle.
  - result is valid and held until the next capture.
  - Update the last-owner pointer; clear err_flag; go IDLE.

Rules:
- The acked requester must drop req in the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- Requests arriving while busy are held by the requester, never dropped by the controller.
- Operand changes after grant have no effect.
- Nominal latency, grant to ack: 1 (LAUNCH) + mul cycles + (WIDTH+3) (SHIFT) + 1 (CLEAR) + 1 (ACK).
- Timeout counters are 8 bits and saturate; they never wrap.

Test Plan:
- Single request: req0, a0=23'h000003, b0=23'h000005; model returns mul_done after 4 cycles, serializer streams 23'h00000F → ack0 one pulse, result=23'h00000F, err=0, ser_clr pulsed once before ack, sz high for exactly 26 cycles.
- Simultaneous req0 and req1 after reset → owner=0 served first, then owner=1 with no idle gap beyond 1 cycle. Three back-to-back dual requests alternate owners 0,1,0.
- mul_done never asserted → after 64 MUL cycles: ack pulses with err=1, sz never high, ser_clr pulsed.
- Serializer asserts fz early (after 10 bits) → err=1 on ack, sz deasserted, no hang.
- rst driven low mid-SHIFT (bit 12) → all outputs 0 immediately. After release, a fresh req1 with 23'h7FFFFF result completes correctly.
- Alternating-bit stream 23'h555555 → result=23'h555555, confirming LSB-first capture order and no off-by-one at bit 0 or bit 22.
